// File: rtl/brush_writer_if.sv
// brush_writer_if
//   Groups the paint/clear request handshake and the pixel-store write strobe
//   of the brush writer.
//   master : request side (brush/cursor logic). Drives req_* and clear_req, and
//            observes req_ready, busy, done and the write strobe.
//   slave  : brush_writer itself.
//   Signals: req_valid/req_ready handshake, req_x/req_y (8b centre),
//            req_color (3b), req_radius (RADIUS_W), clear_req, busy,
//            we/wx/wy/wcolor write strobe, done (last output cycle).
interface brush_writer_if #(
    parameter int RADIUS_W = 2
);
    logic                req_valid;
    logic                req_ready;
    logic [7:0]          req_x;
    logic [7:0]          req_y;
    logic [2:0]          req_color;
    logic [RADIUS_W-1:0] req_radius;
    logic                clear_req;
    logic                busy;
    logic                we;
    logic [7:0]          wx;
    logic [7:0]          wy;
    logic [2:0]          wcolor;
    logic                done;

    modport master (
        output req_valid, req_x, req_y, req_color, req_radius, clear_req,
        input  req_ready, busy, we, wx, wy, wcolor, done
    );

    modport slave (
        input  req_valid, req_x, req_y, req_color, req_radius, clear_req,
        output req_ready, busy, we, wx, wy, wcolor, done
    );
endinterface

// File: rtl/brush_writer.sv
// brush_writer
//   Write-side engine for the square pixel store. Expands a paint request
//   (centre, colour, radius) into a row-major sweep of (2r+1)^2 candidate
//   pixels, one per clock, and a clear command into a full-canvas sweep.
//   Off-canvas candidates still take their cycle but raise no write strobe,
//   so a paint always lasts the same number of cycles.
//   Ports:
//     clk    : system clock
//     reset  : asynchronous, active-low reset
//     bus    : brush_writer_if.slave (request handshake, clear, write strobe)
module brush_writer #(
    parameter int         COORD_W     = 7,
    parameter int         RADIUS_W    = 2,
    parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
    input  logic           clk,
    input  logic           reset,
    brush_writer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;

    localparam logic signed [9:0] CMAX = 10'((1 << COORD_W) - 1);

    state_t                state, state_n;
    logic                  pend, pend_n;
    logic                  rdy_q, rdy_n;
    logic                  accept;

    logic [7:0]            bx, by, bx_n, by_n;
    logic [RADIUS_W-1:0]   br, br_n;
    logic [2:0]            bcol, bcol_n;
    logic [COORD_W-1:0]    ix, iy, ix_n, iy_n;

    logic signed [9:0]     px_n, py_n;
    logic                  busy_q, we_q, done_q;
    logic                  busy_n, we_n, done_n;
    logic [7:0]            wx_q, wy_q, wx_n, wy_n;
    logic [2:0]            wcolor_q, wcolor_n;

    // Highest sweep index along one side of a brush of half-width r.
    function automatic logic [COORD_W-1:0] last_idx(input logic [RADIUS_W-1:0] r);
        return COORD_W'({r, 1'b0});
    endfunction

    // Canvas coordinate of sweep index i around centre base; 10-bit signed so
    // that both negative and beyond-edge positions stay distinguishable.
    function automatic logic signed [9:0] cand(input logic [7:0]          base,
                                               input logic [RADIUS_W-1:0] r,
                                               input logic [COORD_W-1:0]  i);
        return $signed({2'b00, base}) - $signed(10'(r)) + $signed(10'(i));
    endfunction

    function automatic logic in_canvas(input logic signed [9:0] p);
        return (p >= 10'sd0) && (p <= CMAX);
    endfunction

    // Clear requests (fresh or pending) mask the paint handshake so clear wins.
    assign bus.req_ready = rdy_q & ~bus.clear_req;
    assign accept        = bus.req_valid & bus.req_ready;

    always_comb begin
        state_n = state;
        pend_n  = pend;
        bx_n    = bx;
        by_n    = by;
        br_n    = br;
        bcol_n  = bcol;
        ix_n    = ix;
        iy_n    = iy;
        case (state)
            IDLE: begin
                if (bus.clear_req || pend) begin
                    state_n = CLEAR;
                    pend_n  = 1'b0;
                    ix_n    = '0;
                    iy_n    = '0;
                end else if (accept) begin
                    state_n = PAINT;
                    bx_n    = bus.req_x;
                    by_n    = bus.req_y;
                    br_n    = bus.req_radius;
                    bcol_n  = bus.req_color;
                    ix_n    = '0;
                    iy_n    = '0;
                end
            end
            PAINT: begin
                if (bus.clear_req) pend_n = 1'b1;
                if (ix == last_idx(br)) begin
                    ix_n = '0;
                    if (iy == last_idx(br)) state_n = IDLE;
                    else                    iy_n = iy + 1'b1;
                end else begin
                    ix_n = ix + 1'b1;
                end
            end
            CLEAR: begin
                // A clear arriving mid-sweep earns one more full sweep.
                if (bus.clear_req) pend_n = 1'b1;
                ix_n = ix + 1'b1;
                if (&ix) begin
                    if (&iy) state_n = IDLE;
                    else     iy_n = iy + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are precomputed from the next state so the first candidate
    // appears in the cycle right after acceptance.
    always_comb begin
        px_n     = cand(bx_n, br_n, ix_n);
        py_n     = cand(by_n, br_n, iy_n);
        busy_n   = (state_n != IDLE);
        rdy_n    = (state_n == IDLE) & ~pend_n;
        we_n     = 1'b0;
        done_n   = 1'b0;
        wx_n     = '0;
        wy_n     = '0;
        wcolor_n = '0;
        if (state_n == PAINT) begin
            done_n = (ix_n == last_idx(br_n)) && (iy_n == last_idx(br_n));
            if (in_canvas(px_n) && in_canvas(py_n)) begin
                we_n     = 1'b1;
                wx_n     = 8'(px_n[COORD_W-1:0]);
                wy_n     = 8'(py_n[COORD_W-1:0]);
                wcolor_n = bcol_n;
            end
        end else if (state_n == CLEAR) begin
            we_n     = 1'b1;
            wx_n     = 8'(ix_n);
            wy_n     = 8'(iy_n);
            wcolor_n = CLEAR_COLOR;
            done_n   = (&ix_n) & (&iy_n);
        end
    end

    // ---- control and output register stage ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pend     <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            wx_q     <= '0;
            wy_q     <= '0;
            wcolor_q <= '0;
        end else begin
            state    <= state_n;
            pend     <= pend_n;
            rdy_q    <= rdy_n;
            busy_q   <= busy_n;
            we_q     <= we_n;
            done_q   <= done_n;
            wx_q     <= wx_n;
            wy_q     <= wy_n;
            wcolor_q <= wcolor_n;
        end
    end

    // ---- latched request and sweep position (always reloaded on entry) ----
    always_ff @(posedge clk) begin
        bx   <= bx_n;
        by   <= by_n;
        br   <= br_n;
        bcol <= bcol_n;
        ix   <= ix_n;
        iy   <= iy_n;
    end

    assign bus.busy   = busy_q;
    assign bus.we     = we_q;
    assign bus.done   = done_q;
    assign bus.wx     = wx_q;
    assign bus.wy     = wy_q;
    assign bus.wcolor = wcolor_q;
endmodule

// File: tb/tb_brush_writer.sv
// tb_brush_writer
//   Directed bench for brush_writer. A behavioural model (operation kind plus
//   output-cycle index, pixels derived arithmetically from the index) predicts
//   every output cycle and is compared on each falling clock edge; directed
//   sequences add hand-computed literal expectations.
module tb_brush_writer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    brush_writer_if #(.RADIUS_W(2)) bus ();

    brush_writer #(
        .COORD_W    (7),
        .RADIUS_W   (2),
        .CLEAR_COLOR(3'b000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model: kind 0 idle, 1 paint, 2 clear; k = output cycle within the op.
    int kind = 0, k = 0, n = 0, mx = 0, my = 0, mr = 0, mcol = 0;
    bit pend = 1'b0, started = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            kind    <= 0;
            k       <= 0;
            pend    <= 1'b0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (kind != 0) begin
                if (bus.clear_req) pend <= 1'b1;
                if (k + 1 == n) kind <= 0;
                k <= k + 1;
            end else if (bus.clear_req || pend) begin
                kind <= 2;
                k    <= 0;
                n    <= 128 * 128;
                pend <= 1'b0;
            end else if (bus.req_valid && started) begin
                kind <= 1;
                k    <= 0;
                n    <= (2 * int'(bus.req_radius) + 1) * (2 * int'(bus.req_radius) + 1);
                mx   <= int'(bus.req_x);
                my   <= int'(bus.req_y);
                mr   <= int'(bus.req_radius);
                mcol <= int'(bus.req_color);
            end
        end
    end

    function automatic void exp_now(output bit eb, output bit ew, output bit ed,
                                     output bit er, output int ex, output int ey,
                                     output int ec);
        int span, px, py;
        eb = (kind != 0);
        er = (kind == 0) && !pend && started && !bus.clear_req;
        ew = 1'b0; ed = 1'b0; ex = 0; ey = 0; ec = 0;
        if (kind == 1) begin
            span = 2 * mr + 1;
            px = mx + (k % span) - mr;
            py = my + (k / span) - mr;
            ew = (px >= 0) && (px <= 127) && (py >= 0) && (py <= 127);
            ex = px; ey = py; ec = mcol;
            ed = (k == n - 1);
        end else if (kind == 2) begin
            ew = 1'b1;
            ex = k % 128; ey = k / 128; ec = 0;
            ed = (k == 128 * 128 - 1);
        end
    endfunction

    always @(negedge clk) begin
        bit eb, ew, ed, er;
        int ex, ey, ec;
        if (chk_en) begin
            exp_now(eb, ew, ed, er, ex, ey, ec);
            tests++;
            if (bus.busy !== eb || bus.we !== ew || bus.done !== ed || bus.req_ready !== er ||
                (ew && (int'(bus.wx) != ex || int'(bus.wy) != ey || int'(bus.wcolor) != ec))) begin
                fails++;
                $display("FAIL model_cycle t=%0t got busy=%0b we=%0b done=%0b rdy=%0b wx=%0d wy=%0d col=%0d expected busy=%0b we=%0b done=%0b rdy=%0b wx=%0d wy=%0d col=%0d",
                         $time, bus.busy, bus.we, bus.done, bus.req_ready, bus.wx, bus.wy,
                         bus.wcolor, eb, ew, ed, er, ex, ey, ec);
            end
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Presents a request in an idle cycle; returns in output cycle T+1.
    task automatic paint_req(input int x, input int y, input int c, input int r);
        bus.req_x      = 8'(x);
        bus.req_y      = 8'(y);
        bus.req_color  = 3'(c);
        bus.req_radius = 2'(r);
        bus.req_valid  = 1'b1;
        #1;
        chk("ready_before_paint", int'(bus.req_ready), 1);
        cyc();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int nwr, first, hi, nbusy, nrdy, acc, first_done, found;
        bus.req_valid  = 1'b0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_color  = '0;
        bus.req_radius = '0;
        bus.clear_req  = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("reset_we", int'(bus.we), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_ready", int'(bus.req_ready), 0);
        chk_en = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        cyc();
        chk("ready_after_reset", int'(bus.req_ready), 1);

        // 1: r=1 paint at (10,20)
        paint_req(10, 20, 2, 1);
        nwr = 0;
        for (int i = 1; i <= 9; i++) begin
            if (i > 1) cyc();
            if (bus.we) nwr++;
            if (i == 1) begin
                chk("t1_first_wx", int'(bus.wx), 9);
                chk("t1_first_wy", int'(bus.wy), 19);
                chk("t1_first_col", int'(bus.wcolor), 2);
                chk("t1_first_done", int'(bus.done), 0);
            end
            if (i == 5) begin
                chk("t1_mid_wx", int'(bus.wx), 10);
                chk("t1_mid_wy", int'(bus.wy), 20);
            end
            if (i == 9) begin
                chk("t1_last_wx", int'(bus.wx), 11);
                chk("t1_last_wy", int'(bus.wy), 21);
                chk("t1_last_done", int'(bus.done), 1);
            end
        end
        chk("t1_writes", nwr, 9);
        cyc();
        chk("t1_busy_after", int'(bus.busy), 0);
        chk("t1_ready_after", int'(bus.req_ready), 1);

        // 2: corner clip r=2 at (0,0)
        paint_req(0, 0, 5, 2);
        nwr = 0; first = -1; hi = 0; nbusy = 0;
        for (int i = 1; i <= 26; i++) begin
            if (i > 1) cyc();
            if (bus.busy) nbusy++;
            if (bus.we) begin
                nwr++;
                if (first < 0) first = i;
                if (bus.wx >= 126 || bus.wy >= 126) hi++;
            end
        end
        chk("t2_busy_cycles", nbusy, 25);
        chk("t2_writes", nwr, 9);
        chk("t2_first_we_cycle", first, 13);
        chk("t2_wrapped_writes", hi, 0);

        // 3: fully off-canvas r=0
        paint_req(200, 5, 6, 0);
        chk("t3_busy", int'(bus.busy), 1);
        chk("t3_we", int'(bus.we), 0);
        chk("t3_done", int'(bus.done), 1);
        cyc();
        chk("t3_busy_after", int'(bus.busy), 0);

        // 4: clear from idle
        bus.clear_req = 1'b1;
        #1;
        chk("t4_ready_masked", int'(bus.req_ready), 0);
        cyc();
        bus.clear_req = 1'b0;
        nwr = 0; nrdy = 0;
        for (int i = 1; i <= 16384; i++) begin
            if (i > 1) cyc();
            if (bus.we) nwr++;
            if (bus.req_ready) nrdy++;
            if (i == 1) begin
                chk("t4_first_wx", int'(bus.wx), 0);
                chk("t4_first_wy", int'(bus.wy), 0);
                chk("t4_first_col", int'(bus.wcolor), 0);
            end
            if (i == 16384) begin
                chk("t4_last_wx", int'(bus.wx), 127);
                chk("t4_last_wy", int'(bus.wy), 127);
                chk("t4_last_done", int'(bus.done), 1);
            end
        end
        chk("t4_writes", nwr, 16384);
        chk("t4_ready_cycles", nrdy, 0);
        cyc();
        chk("t4_busy_after", int'(bus.busy), 0);

        // 5: clear during r=3 paint with a held request behind it
        paint_req(60, 60, 7, 3);
        acc = -1; first_done = -1;
        for (int c = 1; c <= 20000; c++) begin
            if (c > 1) cyc();
            if (bus.done && first_done < 0) first_done = c;
            if (c == 50) chk("t5_idle_gap_busy", int'(bus.busy), 0);
            if (c == 51) chk("t5_clear_started", int'(bus.busy), 1);
            if (bus.req_valid && bus.req_ready) begin
                acc = c;
                break;
            end
            if (c == 3) begin
                bus.clear_req  = 1'b1;
                bus.req_valid  = 1'b1;
                bus.req_x      = 8'd1;
                bus.req_y      = 8'd1;
                bus.req_radius = 2'd0;
                bus.req_color  = 3'd4;
            end
            if (c == 4) bus.clear_req = 1'b0;
        end
        chk("t5_paint_done_cycle", first_done, 49);
        chk("t5_accept_cycle", acc, 16435);
        cyc();
        bus.req_valid = 1'b0;
        chk("t5_held_we", int'(bus.we), 1);
        chk("t5_held_wx", int'(bus.wx), 1);
        chk("t5_held_wy", int'(bus.wy), 1);
        chk("t5_held_col", int'(bus.wcolor), 4);
        chk("t5_held_done", int'(bus.done), 1);
        cyc();

        // 6: reset mid-clear with a clear pending
        bus.clear_req = 1'b1;
        cyc();
        bus.clear_req = 1'b0;
        found = 0;
        for (int i = 1; i <= 2000; i++) begin
            if (bus.wx == 8'd40 && bus.wy == 8'd7 && bus.we) begin
                found = 1;
                break;
            end
            if (i == 100) bus.clear_req = 1'b1;
            if (i == 101) bus.clear_req = 1'b0;
            cyc();
        end
        chk("t6_reached_40_7", found, 1);
        #1 reset = 1'b0;
        #1;
        chk("t6_we_async", int'(bus.we), 0);
        chk("t6_busy_async", int'(bus.busy), 0);
        chk("t6_ready_in_reset", int'(bus.req_ready), 0);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        chk("t6_ready_after", int'(bus.req_ready), 1);
        nbusy = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (bus.busy || bus.we) nbusy++;
        end
        chk("t6_no_resumed_clear", nbusy, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
